// File: rtl/alu_sequencer_if.sv
// Bus between the ALU sequencer and its controller: start/operand request in,
// register-file/ALU strobes and status out.
interface alu_sequencer_if;
    logic        start;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        stall;

    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  alu_op;
    logic [3:0]  reg_sel;
    logic        r_out;
    logic        r_in;
    logic        y_in;
    logic        z_in;
    logic        zlow_out;
    logic [15:0] op_count;

    modport master (
        output start, op, ra, rb, rc, stall,
        input  busy, done, err, alu_op, reg_sel,
        input  r_out, r_in, y_in, z_in, zlow_out, op_count
    );

    modport slave (
        input  start, op, ra, rb, rc, stall,
        output busy, done, err, alu_op, reg_sel,
        output r_out, r_in, y_in, z_in, zlow_out, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences one register-to-register ALU operation over a shared bus:
// Y <- rb, Z <- Y op rc (or op rb for unary ops), ra <- Zlow.
module alu_sequencer (
    input  logic              clk_i,
    input  logic              clear_i,
    alu_sequencer_if.slave    bus_io
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoadY = 2'd1,
        StExec  = 2'd2,
        StWrite = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  rc_q, rc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] op_count_q, op_count_d;

    logic in_valid;
    logic in_unary;
    logic lat_unary;

    // Ops 0..10 are defined; 2 (NOT) and 10 (NEG) take only rb.
    assign in_valid  = (bus_io.op <= 4'd10);
    assign in_unary  = (bus_io.op == 4'd2) || (bus_io.op == 4'd10);
    assign lat_unary = (op_q == 4'd2) || (op_q == 4'd10);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        op_count_d = op_count_q;

        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    op_d = bus_io.op;
                    ra_d = bus_io.ra;
                    rb_d = bus_io.rb;
                    rc_d = bus_io.rc;
                    if (!in_valid) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (in_unary) begin
                        state_d = StExec;
                    end else begin
                        state_d = StLoadY;
                    end
                end
            end
            StLoadY: begin
                if (!bus_io.stall) state_d = StExec;
            end
            StExec: begin
                if (!bus_io.stall) state_d = StWrite;
            end
            StWrite: begin
                if (!bus_io.stall) begin
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    op_count_d = op_count_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q    <= StIdle;
            op_q       <= 4'd0;
            ra_q       <= 4'd0;
            rb_q       <= 4'd0;
            rc_q       <= 4'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rc_q       <= rc_d;
            done_q     <= done_d;
            err_q      <= err_d;
            op_count_q <= op_count_d;
        end
    end

    // Strobes follow the state; a stall blanks them but keeps reg_sel steady.
    always_comb begin
        bus_io.reg_sel  = 4'd0;
        bus_io.r_out    = 1'b0;
        bus_io.r_in     = 1'b0;
        bus_io.y_in     = 1'b0;
        bus_io.z_in     = 1'b0;
        bus_io.zlow_out = 1'b0;

        case (state_q)
            StLoadY: begin
                bus_io.reg_sel = rb_q;
                bus_io.r_out   = !bus_io.stall;
                bus_io.y_in    = !bus_io.stall;
            end
            StExec: begin
                bus_io.reg_sel = lat_unary ? rb_q : rc_q;
                bus_io.r_out   = !bus_io.stall;
                bus_io.z_in    = !bus_io.stall;
            end
            StWrite: begin
                bus_io.reg_sel  = ra_q;
                bus_io.r_in     = !bus_io.stall;
                bus_io.zlow_out = !bus_io.stall;
            end
            default: ;
        endcase
    end

    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.done     = done_q;
    assign bus_io.err      = err_q;
    assign bus_io.alu_op   = op_q;
    assign bus_io.op_count = op_count_q;

endmodule
